// File: rtl/keep_seq_pkg.sv
// Shared types and helpers for the keep-lane sequencer: FIFO entry layout, FSM states,
// and the lowest-set-bit lane encoder.
package keep_seq_pkg;

  localparam int unsigned KEEP_W      = 4;
  localparam int unsigned KEEP_LANE_W = $clog2(KEEP_W);

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
  } keep_entry_t;

  typedef enum logic [0:0] {
    IDLE,
    EMIT
  } seq_state_e;

  // Returns 0 for an all-zero mask; callers flag that case separately as null.
  function automatic logic [KEEP_LANE_W-1:0] lowest_lane(input logic [KEEP_W-1:0] mask);
    logic [KEEP_LANE_W-1:0] idx;
    idx = '0;
    for (int i = KEEP_W - 1; i >= 0; i--) begin
      if (mask[i]) idx = KEEP_LANE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic at_most_one(input logic [KEEP_W-1:0] mask);
    return (mask & (mask - KEEP_W'(1))) == '0;
  endfunction

endpackage

// File: rtl/keep_fifo.sv
// Simple synchronous FIFO holding {last, keep} entries; pointers wrap modulo the depth.
module keep_fifo #(
  parameter int unsigned T_DATA_RATIO = 5,
  parameter int unsigned DATA_DEPTH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic [T_DATA_RATIO-1:0] data_i,
  input  logic                    pop_i,
  output logic [T_DATA_RATIO-1:0] data_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned AW = $clog2(DATA_DEPTH);
  localparam int unsigned CW = $clog2(DATA_DEPTH + 1);

  logic [T_DATA_RATIO-1:0] mem_q [DATA_DEPTH];
  logic [AW-1:0]           wr_ptr_q;
  logic [AW-1:0]           rd_ptr_q;
  logic [CW-1:0]           cnt_q;

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_i && !pop_i) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop_i && !push_i) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = cnt_q == CW'(DATA_DEPTH);
  assign empty_o = cnt_q == '0;

endmodule

// File: rtl/keep_lane_sequencer.sv
// Buffers wide-beat keep/last sideband and walks each keep mask lowest-lane-first,
// emitting one narrow lane select per cycle with the narrow-stream last flag.
module keep_lane_sequencer
  import keep_seq_pkg::*;
#(
  parameter int unsigned T_DATA_RATIO = KEEP_W,
  parameter int unsigned DATA_DEPTH   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [T_DATA_RATIO-1:0]           s_keep_i,
  input  logic                              s_last_i,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  output logic [$clog2(T_DATA_RATIO)-1:0]   m_lane_o,
  output logic                              m_null_o,
  output logic                              m_last_o,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic [$clog2(DATA_DEPTH+1)-1:0]   level_o
);

  localparam int unsigned LANE_W = $clog2(T_DATA_RATIO);
  localparam int unsigned LVL_W  = $clog2(DATA_DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DATA_DEPTH);

  seq_state_e              state_q;
  logic [T_DATA_RATIO-1:0] mask_q;
  logic [T_DATA_RATIO-1:0] mask_rest;
  logic                    last_q;
  logic [LVL_W-1:0]        level_q;
  logic [LVL_W-1:0]        level_d;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    have_entry;
  logic                    final_beat;
  keep_entry_t             wr_entry;
  keep_entry_t             rd_entry;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [LANE_W-1:0]       ld_lane;
  logic                    ld_null;
  logic                    ld_last;

  assign s_ready_o  = level_q < FULL_LVL;
  assign accept     = s_valid_i & s_ready_o;
  // Zero-keep non-last beats carry nothing downstream and are dropped here.
  assign push       = accept & (s_last_i | (|s_keep_i));
  assign have_entry = level_q != '0;
  assign mask_rest  = mask_q & (mask_q - T_DATA_RATIO'(1));
  assign final_beat = mask_rest == '0;
  assign level_o    = level_q;

  assign wr_entry = keep_entry_t'{last: s_last_i, keep: s_keep_i};
  assign ld_lane  = lowest_lane(rd_entry.keep);
  assign ld_null  = rd_entry.keep == '0;
  assign ld_last  = rd_entry.last & at_most_one(rd_entry.keep);

  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      IDLE:    pop = have_entry;
      EMIT:    pop = m_ready_i & final_beat & have_entry;
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      last_q    <= 1'b0;
      level_q   <= '0;
      m_valid_o <= 1'b0;
      m_lane_o  <= '0;
      m_null_o  <= 1'b0;
      m_last_o  <= 1'b0;
    end else begin
      level_q <= level_d;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q   <= EMIT;
            mask_q    <= rd_entry.keep;
            last_q    <= rd_entry.last;
            m_valid_o <= 1'b1;
            m_lane_o  <= ld_lane;
            m_null_o  <= ld_null;
            m_last_o  <= ld_last;
          end
        end
        EMIT: begin
          if (m_ready_i) begin
            if (!final_beat) begin
              mask_q   <= mask_rest;
              m_lane_o <= lowest_lane(mask_rest);
              m_null_o <= 1'b0;
              m_last_o <= last_q & at_most_one(mask_rest);
            end else if (pop) begin
              // Back-to-back reload keeps the narrow stream bubble-free across entries.
              mask_q   <= rd_entry.keep;
              last_q   <= rd_entry.last;
              m_lane_o <= ld_lane;
              m_null_o <= ld_null;
              m_last_o <= ld_last;
            end else begin
              state_q   <= IDLE;
              mask_q    <= '0;
              last_q    <= 1'b0;
              m_valid_o <= 1'b0;
              m_lane_o  <= '0;
              m_null_o  <= 1'b0;
              m_last_o  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  keep_fifo #(
    .T_DATA_RATIO(T_DATA_RATIO + 1),
    .DATA_DEPTH  (DATA_DEPTH)
  ) u_keep_fifo (
    .clk_i  (clk),
    .rst_ni (~rst),
    .push_i (push),
    .data_i (wr_entry),
    .pop_i  (pop),
    .data_o (rd_entry),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // The occupancy counter mirrors the FIFO, so its flags only guard against misuse.
  a_fifo_legal : assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full) && !(pop && fifo_empty));

endmodule
